// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_arbiter
// Brief    : Single-port RAM arbiter between loader (L) and CPU (C) with
//            locked bursts. Define ARB_RR_EN for round-robin conflict
//            resolution in place of fixed L priority with starvation override.
// Revision : 1.0
// ============================================================================
module ram_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int MAX_WAIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              l_req,
    input  logic              l_we,
    input  logic              l_lock,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic [DATA_W-1:0] l_rdata,
    input  logic              c_req,
    input  logic              c_we,
    input  logic              c_lock,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_write,
    output logic              mem_read,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic [1:0]        owner
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_L = 2'd1,
        OWN_C = 2'd2
    } state_t;

    state_t            r_state_q, w_state_d;
    logic              r_l_tag_q, w_l_tag_d;
    logic              r_c_tag_q, w_c_tag_d;
    logic [DATA_W-1:0] r_l_rdata_q, w_l_rdata_d;
    logic [DATA_W-1:0] r_c_rdata_q, w_c_rdata_d;
    logic              w_l_gnt, w_c_gnt;
    logic              w_l_wins;

`ifdef ARB_RR_EN
    // Set when C took the most recent grant; resets to 1 so L wins first.
    logic r_last_c_q, w_last_c_d;

    assign w_l_wins = r_last_c_q;

    always_comb begin
        w_last_c_d = r_last_c_q;
        if (w_l_gnt) begin
            w_last_c_d = 1'b0;
        end else if (w_c_gnt) begin
            w_last_c_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_last_c_q <= 1'b1;
        end else begin
            r_last_c_q <= w_last_c_d;
        end
    end
`else
    localparam logic [3:0] c_MAX_WAIT = 4'(MAX_WAIT);

    logic [3:0] r_l_wait_q, w_l_wait_d;
    logic [3:0] r_c_wait_q, w_c_wait_d;

    assign w_l_wins = (r_c_wait_q != c_MAX_WAIT) || (r_l_wait_q == c_MAX_WAIT);

    // Waits only accumulate in IDLE; a held lock freezes the other side.
    always_comb begin
        w_l_wait_d = r_l_wait_q;
        w_c_wait_d = r_c_wait_q;
        if (!l_req || w_l_gnt) begin
            w_l_wait_d = '0;
        end else if ((r_state_q == IDLE) && (r_l_wait_q != c_MAX_WAIT)) begin
            w_l_wait_d = r_l_wait_q + 4'd1;
        end
        if (!c_req || w_c_gnt) begin
            w_c_wait_d = '0;
        end else if ((r_state_q == IDLE) && (r_c_wait_q != c_MAX_WAIT)) begin
            w_c_wait_d = r_c_wait_q + 4'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_l_wait_q <= '0;
            r_c_wait_q <= '0;
        end else begin
            r_l_wait_q <= w_l_wait_d;
            r_c_wait_q <= w_c_wait_d;
        end
    end
`endif

    always_comb begin
        w_l_gnt = 1'b0;
        w_c_gnt = 1'b0;
        if (!reset) begin
            case (r_state_q)
                OWN_L: w_l_gnt = l_req;
                OWN_C: w_c_gnt = c_req;
                default: begin
                    if (l_req && c_req) begin
                        w_l_gnt = w_l_wins;
                        w_c_gnt = !w_l_wins;
                    end else begin
                        w_l_gnt = l_req;
                        w_c_gnt = c_req;
                    end
                end
            endcase
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            IDLE: begin
                if (w_l_gnt && l_lock) begin
                    w_state_d = OWN_L;
                end else if (w_c_gnt && c_lock) begin
                    w_state_d = OWN_C;
                end
            end
            OWN_L: if (!l_req || !l_lock) w_state_d = IDLE;
            OWN_C: if (!c_req || !c_lock) w_state_d = IDLE;
            default: w_state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_addr       = '0;
        mem_write_data = '0;
        mem_write      = 1'b0;
        mem_read       = 1'b0;
        if (w_l_gnt) begin
            mem_addr       = l_addr;
            mem_write_data = l_wdata;
            mem_write      = l_we;
            mem_read       = !l_we;
        end else if (w_c_gnt) begin
            mem_addr       = c_addr;
            mem_write_data = c_wdata;
            mem_write      = c_we;
            mem_read       = !c_we;
        end
    end

    // RAM data arrives the cycle after the read; route it by the tag, not owner.
    always_comb begin
        w_l_tag_d   = w_l_gnt && !l_we;
        w_c_tag_d   = w_c_gnt && !c_we;
        w_l_rdata_d = r_l_tag_q ? mem_read_data : r_l_rdata_q;
        w_c_rdata_d = r_c_tag_q ? mem_read_data : r_c_rdata_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state_q   <= IDLE;
            r_l_tag_q   <= 1'b0;
            r_c_tag_q   <= 1'b0;
            r_l_rdata_q <= '0;
            r_c_rdata_q <= '0;
        end else begin
            r_state_q   <= w_state_d;
            r_l_tag_q   <= w_l_tag_d;
            r_c_tag_q   <= w_c_tag_d;
            r_l_rdata_q <= w_l_rdata_d;
            r_c_rdata_q <= w_c_rdata_d;
        end
    end

    assign l_gnt    = w_l_gnt;
    assign c_gnt    = w_c_gnt;
    assign l_rvalid = r_l_tag_q;
    assign c_rvalid = r_c_tag_q;
    assign l_rdata  = w_l_rdata_d;
    assign c_rdata  = w_c_rdata_d;
    assign owner    = r_state_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_arbiter
// Brief    : Directed self-checking bench for ram_arbiter with a small RAM.
// Revision : 1.0
// ============================================================================
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        l_req, l_we, l_lock, l_gnt, l_rvalid;
    logic [15:0] l_addr, l_wdata, l_rdata;
    logic        c_req, c_we, c_lock, c_gnt, c_rvalid;
    logic [15:0] c_addr, c_wdata, c_rdata;
    logic [15:0] mem_addr, mem_write_data, mem_read_data;
    logic        mem_write, mem_read;
    logic [1:0]  owner;

    logic        bd_we;
    logic [7:0]  bd_addr;
    logic [15:0] bd_data;
    logic [15:0] ram [0:255];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_WAIT(4)) dut (
        .clock(clk), .reset(reset),
        .l_req(l_req), .l_we(l_we), .l_lock(l_lock), .l_addr(l_addr),
        .l_wdata(l_wdata), .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
        .c_req(c_req), .c_we(c_we), .c_lock(c_lock), .c_addr(c_addr),
        .c_wdata(c_wdata), .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .mem_addr(mem_addr), .mem_write(mem_write), .mem_read(mem_read),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
        .owner(owner)
    );

    // Single-port RAM, 1-cycle registered read; backdoor port for preload.
    always @(posedge clk) begin
        if (bd_we) ram[bd_addr] <= bd_data;
        else if (mem_write) ram[mem_addr[7:0]] <= mem_write_data;
        if (mem_read) mem_read_data <= ram[mem_addr[7:0]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        l_req = 1'b1; l_we = 1'b1; l_lock = 1'b0; l_addr = '0; l_wdata = '0;
        c_req = 1'b1; c_we = 1'b0; c_lock = 1'b0; c_addr = '0; c_wdata = '0;
        bd_we = 1'b1; bd_addr = 8'h10; bd_data = 16'hBEEF;

        // Reset with both requesting
        next();
        bd_addr = 8'h20; bd_data = 16'h00AA;
        #1;
        chk("rst_l_gnt", l_gnt, 0);
        chk("rst_c_gnt", c_gnt, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_mem_read", mem_read, 0);
        chk("rst_owner", owner, 0);
        chk("rst_l_rvalid", l_rvalid, 0);
        chk("rst_c_rvalid", c_rvalid, 0);
        chk("rst_l_rdata", l_rdata, 0);
        chk("rst_c_rdata", c_rdata, 0);
        next();
        bd_we = 1'b0;
        #1;
        chk("rst2_l_gnt", l_gnt, 0);
        chk("rst2_c_gnt", c_gnt, 0);

        // Single CPU read
        reset = 1'b0; l_req = 1'b0;
        c_req = 1'b1; c_we = 1'b0; c_addr = 16'h0010;
        #1;
        chk("rd_c_gnt", c_gnt, 1);
        chk("rd_l_gnt", l_gnt, 0);
        chk("rd_mem_read", mem_read, 1);
        chk("rd_mem_addr", mem_addr, 16'h0010);
        next();
        c_req = 1'b0;
        #1;
        chk("rd_c_rvalid", c_rvalid, 1);
        chk("rd_c_rdata", c_rdata, 16'hBEEF);
        chk("rd_l_rvalid", l_rvalid, 0);
        chk("rd_idle_mem_read", mem_read, 0);
        chk("rd_idle_mem_addr", mem_addr, 0);
        next();
        chk("rd_c_rvalid_drop", c_rvalid, 0);
        chk("rd_c_rdata_hold", c_rdata, 16'hBEEF);

        // Locked loader burst while the CPU keeps requesting
        l_req = 1'b1; l_we = 1'b1; l_lock = 1'b1;
        c_req = 1'b1; c_we = 1'b0; c_addr = 16'h0010;
        for (int i = 0; i < 8; i++) begin
            l_addr = 16'(i); l_wdata = 16'h1000 + 16'(i);
            #1;
            chk("burst_l_gnt", l_gnt, 1);
            chk("burst_c_gnt", c_gnt, 0);
            chk("burst_mem_write", mem_write, 1);
            chk("burst_mem_addr", mem_addr, 32'(i));
            chk("burst_mem_wdata", mem_write_data, 32'h1000 + 32'(i));
            chk("burst_owner", owner, (i == 0) ? 0 : 1);
            next();
        end
        l_req = 1'b0; l_lock = 1'b0;
        #1;
        chk("burst_end_c_gnt", c_gnt, 0);
        chk("burst_end_owner", owner, 1);
        next();
        chk("after_burst_c_gnt", c_gnt, 1);
        chk("after_burst_owner", owner, 0);
        next();
        c_req = 1'b0;

        // Readback of the burst, back-to-back reads
        l_we = 1'b0;
        for (int i = 0; i <= 8; i++) begin
            l_req = (i < 8);
            l_addr = 16'(i);
            #1;
            if (i < 8) chk("rb_l_gnt", l_gnt, 1);
            if (i > 0) begin
                chk("rb_l_rvalid", l_rvalid, 1);
                chk("rb_l_rdata", l_rdata, 32'h1000 + 32'(i - 1));
            end
            next();
        end

        // Continuous conflict, no locks
        l_req = 1'b1; l_we = 1'b0; l_addr = 16'h0000;
        c_req = 1'b1; c_we = 1'b0; c_addr = 16'h0000;
        for (int k = 0; k < 10; k++) begin
`ifdef ARB_RR_EN
            // Last grant before this was L, so C takes the first conflict.
            logic exp_c;
            exp_c = (k % 2 == 0);
`else
            logic exp_c;
            exp_c = (k == 4) || (k == 9);
`endif
            #1;
            chk("starve_l_gnt", l_gnt, !exp_c);
            chk("starve_c_gnt", c_gnt, exp_c);
            next();
        end
        l_req = 1'b0; c_req = 1'b0;
        next();

        // Ownership change during read return
        c_req = 1'b1; c_we = 1'b0; c_addr = 16'h0020;
        #1;
        chk("own_c_gnt", c_gnt, 1);
        next();
        c_req = 1'b0;
        l_req = 1'b1; l_we = 1'b0; l_addr = 16'h0010;
        #1;
        chk("own_l_gnt", l_gnt, 1);
        chk("own_c_rvalid", c_rvalid, 1);
        chk("own_c_rdata", c_rdata, 16'h00AA);
        chk("own_l_rvalid", l_rvalid, 0);
        next();
        l_req = 1'b0;
        #1;
        chk("own2_l_rvalid", l_rvalid, 1);
        chk("own2_l_rdata", l_rdata, 16'hBEEF);
        chk("own2_c_rvalid", c_rvalid, 0);
        next();

        // Read-after-write to the same address on consecutive cycles
        l_req = 1'b1; l_we = 1'b1; l_addr = 16'h0030; l_wdata = 16'h5A5A;
        #1;
        chk("raw_l_gnt", l_gnt, 1);
        next();
        l_req = 1'b0;
        c_req = 1'b1; c_we = 1'b0; c_addr = 16'h0030;
        #1;
        chk("raw_c_gnt", c_gnt, 1);
        next();
        c_req = 1'b0;
        #1;
        chk("raw_c_rvalid", c_rvalid, 1);
        chk("raw_c_rdata", c_rdata, 16'h5A5A);
        next();

        // Reset in the third cycle of a locked loader burst
        l_req = 1'b1; l_we = 1'b1; l_lock = 1'b1; l_addr = 16'h0040; l_wdata = 16'h4040;
        c_req = 1'b1; c_we = 1'b0; c_addr = 16'h0010;
        #1;
        chk("mid_c1_l_gnt", l_gnt, 1);
        next();
        l_addr = 16'h0041;
        #1;
        chk("mid_c2_l_gnt", l_gnt, 1);
        chk("mid_c2_owner", owner, 1);
        next();
        reset = 1'b1; l_addr = 16'h0042;
        #1;
        chk("mid_rst_l_gnt", l_gnt, 0);
        chk("mid_rst_c_gnt", c_gnt, 0);
        chk("mid_rst_mem_write", mem_write, 0);
        next();
        reset = 1'b0; l_req = 1'b0; l_lock = 1'b0;
        #1;
        chk("mid_post_owner", owner, 0);
        chk("mid_post_c_gnt", c_gnt, 1);
        chk("mid_post_c_rvalid", c_rvalid, 0);
        next();
        c_req = 1'b0;
        #1;
        chk("mid_post_c_rdata", c_rdata, 16'hBEEF);
        next();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
